// File: rtl/lfsr_scramble_stream.sv
// Streaming Fibonacci-LFSR scrambler/descrambler with valid/ready, runtime seed load and
// a sticky dead-state flag. Defining LFSR_SCRAMBLE_STREAM_BYPASS_EN adds the bypass input.
module lfsr_scramble_stream #(
  parameter int                    LFSR_WIDTH = 58,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 58'h8000000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = {LFSR_WIDTH{1'b1}},
  parameter string                 MODE       = "SCRAMBLE",
  parameter bit                    REVERSE    = 1'b1,
  parameter int                    DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic                  dead_state
);

  localparam int MODE_SEL = (MODE == "ADDITIVE") ? 2 : (MODE == "DESCRAMBLE") ? 1 : 0;

  logic [LFSR_WIDTH-1:0] state_reg, state_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  dead_reg, dead_next;
  logic                  accept;
  logic [DATA_WIDTH-1:0] y_vec;
  logic [LFSR_WIDTH-1:0] chain [0:DATA_WIDTH];

  // Top term of the polynomial is the oldest bit; poly bit j taps state bit j-1.
  function automatic logic tap_xor(input logic [LFSR_WIDTH-1:0] st);
    logic fb;
    fb = st[LFSR_WIDTH-1];
    for (int j = 1; j < LFSR_WIDTH; j++) begin
      if (LFSR_POLY[j]) fb = fb ^ st[j-1];
    end
    return fb;
  endfunction

  assign chain[0] = state_reg;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      localparam int BI = REVERSE ? gi : DATA_WIDTH - 1 - gi;
      logic d_bit, s_bit, y_bit, in_bit;

      assign d_bit = s_data[BI];
      assign s_bit = tap_xor(chain[gi]);
      assign y_bit = d_bit ^ s_bit;

      if (MODE_SEL == 2) begin : g_add
        assign in_bit = s_bit;
      end else if (MODE_SEL == 1) begin : g_dsc
        assign in_bit = d_bit;
      end else begin : g_scr
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
        // Bypassed beats feed raw data so the scrambler sequence stays deterministic.
        assign in_bit = bypass ? d_bit : y_bit;
`else
        assign in_bit = y_bit;
`endif
      end

      assign chain[gi+1] = {chain[gi][LFSR_WIDTH-2:0], in_bit};
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
      assign y_vec[BI] = bypass ? d_bit : y_bit;
`else
      assign y_vec[BI] = y_bit;
`endif
    end
  endgenerate

  assign s_ready = !valid_reg || m_ready;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    dead_next  = dead_reg;
    if (accept) begin
      state_next = chain[DATA_WIDTH];
      data_next  = y_vec;
      valid_next = 1'b1;
    end else if (m_ready) begin
      valid_next = 1'b0;
    end
    // A coincident beat still uses the pre-load state; the seed owns the register.
    if (seed_load) state_next = seed_value;
    if (seed_load && (seed_value != '0)) dead_next = 1'b0;
    else if (state_reg == '0)            dead_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LFSR_INIT;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      dead_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      dead_reg  <= dead_next;
    end
  end

  assign m_data     = data_reg;
  assign m_valid    = valid_reg;
  assign dead_state = dead_reg;

endmodule

// File: tb/tb_lfsr_scramble_stream.sv
// Scoreboard bench for lfsr_scramble_stream: PRBS7 additive unit, scrambler->descrambler
// chain, and a backpressure/reset unit, each checked against a bit-serial reference.
module tb_lfsr_scramble_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_bp;
  int   n_cmp = 0;
  int   n_bad = 0;

  // PRBS7 additive unit
  logic [0:0] add_s_data, add_m_data;
  logic       add_s_valid, add_s_ready, add_m_valid, add_m_ready;
  logic       add_seed_load, add_dead;
  logic [6:0] add_seed_value, add_st;
  // scrambler -> descrambler chain
  logic [63:0] scr_s_data, scr_m_data, dsc_m_data;
  logic        scr_s_valid, scr_s_ready, scr_m_valid;
  logic        dsc_s_ready, dsc_m_valid, dsc_m_ready, scr_dead, dsc_dead;
  logic [57:0] scr_st;
  // backpressure / reset unit
  logic [63:0] bp_s_data, bp_m_data, bp_last;
  logic        bp_s_valid, bp_s_ready, bp_m_valid, bp_m_ready, bp_dead;
  logic [57:0] bp_st;

  logic        exp_add[$];
  logic [63:0] exp_scr[$], exp_dsc[$], exp_bp[$];
  logic        add_log[$];
  bit          add_logging = 1'b0;
  int          dsc_seen = 0;

  lfsr_scramble_stream #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_INIT(7'h7F),
      .MODE("ADDITIVE"), .REVERSE(1'b1), .DATA_WIDTH(1)) u_add (
    .clk(clk), .rst(rst), .s_data(add_s_data), .s_valid(add_s_valid), .s_ready(add_s_ready),
    .m_data(add_m_data), .m_valid(add_m_valid), .m_ready(add_m_ready),
    .seed_load(add_seed_load), .seed_value(add_seed_value),
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
    .bypass(1'b0),
`endif
    .dead_state(add_dead));

  lfsr_scramble_stream #(.MODE("SCRAMBLE")) u_scr (
    .clk(clk), .rst(rst), .s_data(scr_s_data), .s_valid(scr_s_valid), .s_ready(scr_s_ready),
    .m_data(scr_m_data), .m_valid(scr_m_valid), .m_ready(dsc_s_ready),
    .seed_load(1'b0), .seed_value(58'd0),
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
    .bypass(1'b0),
`endif
    .dead_state(scr_dead));

  lfsr_scramble_stream #(.MODE("DESCRAMBLE"), .LFSR_INIT(58'h0123456789ABCDE)) u_dsc (
    .clk(clk), .rst(rst), .s_data(scr_m_data), .s_valid(scr_m_valid), .s_ready(dsc_s_ready),
    .m_data(dsc_m_data), .m_valid(dsc_m_valid), .m_ready(dsc_m_ready),
    .seed_load(1'b0), .seed_value(58'd0),
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
    .bypass(1'b0),
`endif
    .dead_state(dsc_dead));

  lfsr_scramble_stream #(.MODE("SCRAMBLE")) u_bp (
    .clk(clk), .rst(rst_bp), .s_data(bp_s_data), .s_valid(bp_s_valid), .s_ready(bp_s_ready),
    .m_data(bp_m_data), .m_valid(bp_m_valid), .m_ready(bp_m_ready),
    .seed_load(1'b0), .seed_value(58'd0),
`ifdef LFSR_SCRAMBLE_STREAM_BYPASS_EN
    .bypass(1'b0),
`endif
    .dead_state(bp_dead));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected output beat %h", name, act);
  endtask

  // x^7 + x^6 + 1: taps are the two oldest bits
  task automatic prbs7_step(input logic d, inout logic [6:0] st, output logic y);
    logic s;
    s  = st[6] ^ st[5];
    y  = d ^ s;
    st = {st[5:0], s};
  endtask

  // x^58 + x^39 + 1, LSB first; mode 0 scramble, 1 descramble, 2 additive
  task automatic s58_step(input logic [63:0] d, input int mode, inout logic [57:0] st,
                          output logic [63:0] y);
    logic s, fb;
    for (int i = 0; i < 64; i++) begin
      s    = st[57] ^ st[38];
      y[i] = d[i] ^ s;
      fb   = (mode == 0) ? y[i] : (mode == 1) ? d[i] : s;
      st   = {st[56:0], fb};
    end
  endtask

  task automatic add_send(input logic d, input logic do_seed, input logic [6:0] seed);
    logic y;
    int   t;
    add_s_data  = d;
    add_s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!add_s_ready && t < 200) begin @(negedge clk); t++; end
    if (!add_s_ready) begin
      unexpected("add_send_timeout", 64'd0);
    end else begin
      prbs7_step(d, add_st, y);
      exp_add.push_back(y);
      if (do_seed) begin
        add_seed_value = seed;
        add_seed_load  = 1'b1;
        add_st         = seed;
      end
    end
    @(posedge clk); #1;
    add_s_valid   = 1'b0;
    add_seed_load = 1'b0;
  endtask

  task automatic add_seed_only(input logic [6:0] seed);
    add_seed_value = seed;
    add_seed_load  = 1'b1;
    @(posedge clk); #1;
    add_seed_load = 1'b0;
    add_st        = seed;
  endtask

  task automatic scr_send(input logic [63:0] d);
    logic [63:0] y;
    int t;
    scr_s_data  = d;
    scr_s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!scr_s_ready && t < 200) begin @(negedge clk); t++; end
    if (!scr_s_ready) begin
      unexpected("scr_send_timeout", d);
    end else begin
      s58_step(d, 0, scr_st, y);
      exp_scr.push_back(y);
      exp_dsc.push_back(d);
    end
    @(posedge clk); #1;
    scr_s_valid = 1'b0;
  endtask

  task automatic bp_send(input logic [63:0] d);
    logic [63:0] y;
    int t;
    bp_s_data  = d;
    bp_s_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!bp_s_ready && t < 200) begin @(negedge clk); t++; end
    if (!bp_s_ready) begin
      unexpected("bp_send_timeout", d);
    end else begin
      s58_step(d, 0, bp_st, y);
      exp_bp.push_back(y);
      bp_last = y;
    end
    @(posedge clk); #1;
    bp_s_valid = 1'b0;
  endtask

  // Monitors: pop and compare whenever a beat is handed downstream.
  always @(negedge clk) begin
    if (add_m_valid && add_m_ready) begin
      if (exp_add.size() == 0) unexpected("add_out", {63'd0, add_m_data});
      else check("add_out", {63'd0, add_m_data}, {63'd0, exp_add.pop_front()});
      if (add_logging) add_log.push_back(add_m_data[0]);
    end
    if (scr_m_valid && dsc_s_ready) begin
      if (exp_scr.size() == 0) unexpected("scr_out", scr_m_data);
      else check("scr_out", scr_m_data, exp_scr.pop_front());
    end
    if (dsc_m_valid && dsc_m_ready) begin
      if (exp_dsc.size() == 0) unexpected("dsc_out", dsc_m_data);
      else if (dsc_seen == 0) void'(exp_dsc.pop_front());
      else check("dsc_out", dsc_m_data, exp_dsc.pop_front());
      dsc_seen++;
    end
    if (bp_m_valid && bp_m_ready) begin
      if (exp_bp.size() == 0) unexpected("bp_out", bp_m_data);
      else check("bp_out", bp_m_data, exp_bp.pop_front());
    end
  end

  initial begin
    int ones;
    int t;
    bit per_ok;
    rst = 1'b1; rst_bp = 1'b1;
    add_s_data = '0; add_s_valid = 1'b0; add_m_ready = 1'b1;
    add_seed_load = 1'b0; add_seed_value = '0;
    scr_s_data = '0; scr_s_valid = 1'b0; dsc_m_ready = 1'b1;
    bp_s_data = '0; bp_s_valid = 1'b0; bp_m_ready = 1'b1; bp_last = '0;
    add_st = 7'h7F; scr_st = '1; bp_st = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; rst_bp = 1'b0;

    check("rst_m_valid", {63'd0, add_m_valid}, 64'd0);
    check("rst_m_data", {63'd0, add_m_data}, 64'd0);
    check("rst_s_ready", {63'd0, add_s_ready}, 64'd1);
    check("rst_dead", {63'd0, add_dead}, 64'd0);
    check("rst_bp_s_ready", {63'd0, bp_s_ready}, 64'd1);

    // PRBS7: two full periods of additive output with zero data
    add_logging = 1'b1;
    for (int k = 0; k < 254; k++) add_send(1'b0, 1'b0, 7'h00);
    repeat (2) @(posedge clk);
    #1;
    add_logging = 1'b0;
    check("prbs_len", 64'(add_log.size()), 64'd254);
    if (add_log.size() == 254) begin
      ones = 0;
      per_ok = 1'b1;
      for (int i = 0; i < 127; i++) begin
        ones += int'(add_log[i]);
        if (add_log[i+127] !== add_log[i]) per_ok = 1'b0;
      end
      check("prbs_ones", 64'(ones), 64'd64);
      check("prbs_period", {63'd0, per_ok}, 64'd1);
    end
    check("prbs_dead", {63'd0, add_dead}, 64'd0);

    // Zero seed kills the additive sequence; a nonzero seed revives it
    add_seed_only(7'h00);
    @(posedge clk); #1;
    check("dead_set", {63'd0, add_dead}, 64'd1);
    for (int k = 0; k < 3; k++) add_send(1'b1, 1'b0, 7'h00);
    check("dead_sticky", {63'd0, add_dead}, 64'd1);
    add_seed_only(7'h01);
    check("dead_clear", {63'd0, add_dead}, 64'd0);
    for (int k = 0; k < 20; k++) add_send(1'b0, 1'b0, 7'h00);
    check("dead_stays_clear", {63'd0, add_dead}, 64'd0);

    // Seed coincident with an accepted beat
    add_send(1'b0, 1'b1, 7'h55);
    for (int k = 0; k < 12; k++) add_send(1'b0, 1'b0, 7'h00);

    // Scrambler feeding descrambler with a different initial state
    for (int k = 0; k < 100; k++) scr_send({$urandom, $urandom});

    // Backpressure: the held beat must stay put and the sequence must continue unbroken
    bp_m_ready = 1'b0;
    bp_send(64'hDEADBEEF00000001);
    bp_s_data  = 64'h0123456789ABCDEF;
    bp_s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_valid", {63'd0, bp_m_valid}, 64'd1);
      check("bp_hold_data", bp_m_data, bp_last);
      check("bp_hold_s_ready", {63'd0, bp_s_ready}, 64'd0);
      @(posedge clk); #1;
    end
    bp_m_ready = 1'b1;
    bp_send(64'h0123456789ABCDEF);
    bp_send(64'hFFFF0000FFFF0000);
    bp_send(64'h0000000000000000);
    @(posedge clk); #1;
    check("bp_valid_fall", {63'd0, bp_m_valid}, 64'd0);

    // Reset while a beat is held
    bp_m_ready = 1'b0;
    bp_send(64'h5555AAAA5555AAAA);
    check("pre_rst_valid", {63'd0, bp_m_valid}, 64'd1);
    check("pre_rst_pending", 64'(exp_bp.size()), 64'd1);
    exp_bp.delete();
    rst_bp = 1'b1;
    @(posedge clk); #1;
    rst_bp = 1'b0;
    check("post_rst_valid", {63'd0, bp_m_valid}, 64'd0);
    check("post_rst_data", bp_m_data, 64'd0);
    check("post_rst_s_ready", {63'd0, bp_s_ready}, 64'd1);
    bp_st = '1;
    bp_m_ready = 1'b1;
    bp_send(64'hA5A5A5A5A5A5A5A5);
    bp_send(64'h0F0F0F0F0F0F0F0F);

    t = 0;
    while ((exp_add.size() + exp_scr.size() + exp_dsc.size() + exp_bp.size()) != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    check("drain_add", 64'(exp_add.size()), 64'd0);
    check("drain_scr", 64'(exp_scr.size()), 64'd0);
    check("drain_dsc", 64'(exp_dsc.size()), 64'd0);
    check("drain_bp", 64'(exp_bp.size()), 64'd0);
    check("dsc_beats", 64'(dsc_seen), 64'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_scramble_stream.md
# lfsr_scramble_stream

Streaming LFSR scrambler/descrambler with valid/ready flow control, selectable additive or self-synchronous mode, runtime seed load, and a dead-state monitor. It sits between a PCS encoder/decoder and the gearbox. It replaces free-running, enable-only scramblers where the datapath has backpressure or must be re-seeded at run time. The per-bit next-state math comes from the `lfsr` module in Fibonacci configuration.

## Interface
- LFSR_WIDTH, 58, LFSR register width.
- LFSR_POLY, 58'h8000000001, tap polynomial; implicit top term.
- LFSR_INIT, all ones, state after reset.
- MODE, "SCRAMBLE", one of "SCRAMBLE" (self-sync), "DESCRAMBLE" (self-sync), "ADDITIVE".
- REVERSE, 1, LSB-first bit order when 1.
- DATA_WIDTH, 64, bits per beat; one LFSR shift per bit.
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- s_data  input  DATA_WIDTH  input beat.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept a beat.
- m_data  output  DATA_WIDTH  processed beat.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts.
- seed_load  input  1  load seed_value into state.
- seed_value  input  LFSR_WIDTH  seed.
- dead_state  output  1  sticky; state reached all-zero.

## Operation
- Per data bit d, in REVERSE order: s = XOR of the state bits selected by LFSR_POLY; y = d ^ s.
- State update by MODE:
  - SCRAMBLE: state shifts in y.
  - DESCRAMBLE: state shifts in d.
  - ADDITIVE: state shifts in s, independent of data.
- A beat is accepted when s_valid && s_ready.
- On accept: m_data and state update together from the whole beat, all DATA_WIDTH bits unrolled.
- No accept: state holds.
- seed_load: state <= seed_value at the clock edge.
  - If a beat is accepted in the same cycle, that beat is processed with the pre-load state, and the seed wins the state register.
  - The seed does not disturb m_data/m_valid.
- dead_state is set when the registered state equals 0.
  - In ADDITIVE mode this means permanent zero PRBS.
  - It clears only on rst or on a seed_load with nonzero seed_value.
- Reset values: state = LFSR_INIT, m_data = 0, m_valid = 0, dead_state = 0. s_ready = 1 after reset.
- rst mid-stream drops any held output beat. No partial output.

## Timing
- Latency: 1 cycle, from accept to m_valid.
- One output register stage. s_ready = !m_valid || m_ready (combinational from m_ready). Full throughput of 1 beat/cycle with m_ready held high.
- m_valid high with m_ready low: m_data stable, s_ready low, state frozen.
- m_valid falls the cycle after m_ready sampled high only when no new beat is accepted in that cycle.
- s_valid may drop without an accept; no state change.
- Self-sync descrambler converges after LFSR_WIDTH received bits. With DATA_WIDTH ≥ LFSR_WIDTH, every beat after the first accepted beat is correct regardless of seed.

## Configuration
- Macro LFSR_SCRAMBLE_STREAM_BYPASS_EN.
- Defined: adds input port `bypass` (1 bit).
  - When high at accept: m_data = s_data, same latency and handshake.
  - State still advances per MODE. In SCRAMBLE mode the state shifts in the unscrambled s_data so the sequence stays deterministic.
- Not defined: no port, no bypass logic; behaviour as above.

## Test plan
- ADDITIVE, LFSR_WIDTH 7, POLY 7'h41, INIT 7'h7F, DATA_WIDTH 1, s_data=0 continuously, m_ready=1 -> m_data is PRBS7: period exactly 127 beats, 64 ones per period, dead_state stays 0.
- SCRAMBLE (default params, INIT all ones) feeding DESCRAMBLE (INIT 58'h0123456789ABCDE), 100 random 64-bit beats -> descrambler output equals the original from beat 1 onward; beat 0 may differ.
- Backpressure: m_ready=0 for 3 cycles after an accepted beat 64'hDEADBEEF00000001 -> m_data held, s_ready=0, state unchanged. m_ready=1 -> the next beat continues the sequence with no gap versus the no-stall golden.
- ADDITIVE: seed_load with seed_value=0 -> dead_state=1 within 1 cycle. Then seed_load with 7'h01 -> dead_state=0 and the PRBS resumes from seed 7'h01.
- seed_load coincident with an accepted beat -> that beat matches the old-state golden; the next beat matches the golden started from seed_value.
- rst asserted while m_valid=1 and m_ready=0 -> next cycle m_valid=0, m_data=0, state=LFSR_INIT, s_ready=1.
